// File: rtl/weight_acc_ctrl_if.sv
// Weight stream in from the unified buffer and the broadcast/strobe bus out to the
// accumulator bank of one systolic row.
interface weight_acc_ctrl_if #(
   parameter int NUM_COLS = 2
);
   // Handshake: a weight beat transfers on a rising edge where wt_valid && wt_ready.
   // The source holds wt_data while wt_valid is high. wt_ready does not depend on wt_valid.
   logic                wt_valid;
   logic [15:0]         wt_data;
   logic                wt_ready;
   logic [15:0]         acc_data_out;
   logic [NUM_COLS-1:0] acc_valid_data_out;
   logic [NUM_COLS-1:0] acc_valid_in_out;

   modport slave (
      input  wt_valid, wt_data,
      output wt_ready, acc_data_out, acc_valid_data_out, acc_valid_in_out
   );

   modport master (
      output wt_valid, wt_data,
      input  wt_ready, acc_data_out, acc_valid_data_out, acc_valid_in_out
   );
endinterface

// File: rtl/weight_acc_ctrl.sv
// Load/drain sequencer for a row of weight accumulators. It loads column-major weights
// through per-column enqueue strobes, then drains them with a diagonal column skew.
module weight_acc_ctrl #(
   parameter int NUM_COLS = 2,
   parameter int DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [7:0]        i_num_rows,
   weight_acc_ctrl_if.slave  bus,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [1:0]        o_state
);

   localparam int CW = $clog2(NUM_COLS) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]          r_state;
   logic [7:0]          r_rows;
   logic [7:0]          r_row_cnt;
   logic [CW-1:0]       r_col_cnt;
   logic [7:0]          r_drain_cnt;
   logic [15:0]         r_acc_data;
   logic [NUM_COLS-1:0] r_enq;
   logic [NUM_COLS-1:0] r_deq;
   logic                r_done;
   logic                r_err;

   logic                w_beat;
   logic                w_last_row;
   logic                w_last_col;
   logic                w_bad_rows;
   logic                w_drain_last;
   logic [NUM_COLS-1:0] w_onehot;
   logic [NUM_COLS-1:0] w_deq;

   assign w_beat       = bus.wt_valid && (r_state == S_LOAD);
   assign w_last_row   = (r_row_cnt == (r_rows - 8'd1));
   assign w_last_col   = (r_col_cnt == CW'(NUM_COLS - 1));
   assign w_bad_rows   = (i_num_rows == 8'd0) || (i_num_rows > 8'(DEPTH));
   assign w_onehot     = NUM_COLS'(1) << r_col_cnt;
   // Compared in 9 bits so rows_q + column offset cannot wrap.
   assign w_drain_last = ({1'b0, r_drain_cnt} == ({1'b0, r_rows} + 9'(NUM_COLS) - 9'd2));

   // Column c dequeues for rows_q cycles starting c cycles into the drain.
   always_comb begin
      w_deq = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         w_deq[c] = ({1'b0, r_drain_cnt} >= 9'(c)) &&
                    ({1'b0, r_drain_cnt} < (9'(c) + {1'b0, r_rows}));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rows      <= '0;
         r_row_cnt   <= '0;
         r_col_cnt   <= '0;
         r_drain_cnt <= '0;
         r_acc_data  <= '0;
         r_enq       <= '0;
         r_deq       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_enq  <= '0;
         r_deq  <= '0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (i_abort && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_drain_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     if (w_bad_rows) begin
                        r_err <= 1'b1;
                     end else begin
                        r_rows      <= i_num_rows;
                        r_row_cnt   <= '0;
                        r_col_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= S_LOAD;
                     end
                  end
               end
               S_LOAD: begin
                  if (w_beat) begin
                     r_acc_data <= bus.wt_data;
                     r_enq      <= w_onehot;
                     if (w_last_row) begin
                        r_row_cnt <= '0;
                        r_col_cnt <= r_col_cnt + CW'(1);
                        if (w_last_col) begin
                           r_state <= S_DRAIN;
                        end
                     end else begin
                        r_row_cnt <= r_row_cnt + 8'd1;
                     end
                  end
               end
               S_DRAIN: begin
                  r_deq <= w_deq;
                  if (w_drain_last) begin
                     r_drain_cnt <= '0;
                     r_state     <= S_DONE;
                  end else begin
                     r_drain_cnt <= r_drain_cnt + 8'd1;
                  end
               end
               S_DONE: begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.wt_ready           = (r_state == S_LOAD);
   assign bus.acc_data_out       = r_acc_data;
   assign bus.acc_valid_data_out = r_enq;
   assign bus.acc_valid_in_out   = r_deq;
   assign o_busy                 = (r_state != S_IDLE);
   assign o_done                 = r_done;
   assign o_err                  = r_err;
   assign o_state                = r_state;

endmodule

// File: tb/tb_weight_acc_ctrl.sv
// Bench for weight_acc_ctrl: directed jobs plus randomized jobs, with a cycle-stamped
// scoreboard of expected enqueue, dequeue, done and err events.
module tb_weight_acc_ctrl;
   localparam int NC    = 2;
   localparam int DEPTH = 4;
   localparam int EW    = 32 + NC;
   localparam int DW    = 16 + NC;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] num_rows;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] state;

   weight_acc_ctrl_if #(.NUM_COLS(NC)) bus ();

   weight_acc_ctrl #(.NUM_COLS(NC), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (start),
      .i_abort    (abort),
      .i_num_rows (num_rows),
      .bus        (bus.slave),
      .o_busy     (busy),
      .o_done     (done),
      .o_err      (err),
      .o_state    (state)
   );

   // ---------------- clock / reset / cycle stamp ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;

   logic [EW-1:0] exp_enq_q[$];   // {cycle, column one-hot, data}
   logic [DW-1:0] exp_deq_q[$];   // {cycle, dequeue vector}
   logic [15:0]   exp_done_q[$];  // cycle
   logic [15:0]   exp_err_q[$];   // cycle

   logic [EW-1:0] m_enq;
   logic [DW-1:0] m_deq;
   logic [15:0]   m_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (exp_enq_q.size() > 0 && exp_enq_q[0][EW-1 -: 16] == cyc[15:0]) begin
            m_enq = exp_enq_q.pop_front();
            check("enq", 64'({cyc[15:0], bus.acc_valid_data_out, bus.acc_data_out}), 64'(m_enq));
         end else if (bus.acc_valid_data_out != '0) begin
            check("enq_unexpected", 64'(bus.acc_valid_data_out), 64'(0));
         end
         if (exp_deq_q.size() > 0 && exp_deq_q[0][DW-1 -: 16] == cyc[15:0]) begin
            m_deq = exp_deq_q.pop_front();
            check("deq", 64'({cyc[15:0], bus.acc_valid_in_out}), 64'(m_deq));
         end else if (bus.acc_valid_in_out != '0) begin
            check("deq_unexpected", 64'(bus.acc_valid_in_out), 64'(0));
         end
         if (exp_done_q.size() > 0 && exp_done_q[0] == cyc[15:0]) begin
            m_cyc = exp_done_q.pop_front();
            check("done", 64'(done), 64'(1));
         end else if (done) begin
            check("done_unexpected", 64'(done), 64'(0));
         end
         if (exp_err_q.size() > 0 && exp_err_q[0] == cyc[15:0]) begin
            m_cyc = exp_err_q.pop_front();
            check("err", 64'(err), 64'(1));
         end else if (err) begin
            check("err_unexpected", 64'(err), 64'(0));
         end
      end
   end

   // ---------------- reference model ----------------
   // After the last beat lands on edge le, column c dequeues on the rows cycles
   // starting at le+1+c; done follows the final dequeue cycle.
   task automatic expect_drain(input int rows, input int unsigned le);
      logic [NC-1:0] sched[$];
      for (int t = 0; t < rows + NC - 1; t++) sched.push_back('0);
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < rows; r++) sched[c + r][c] = 1'b1;
      for (int t = 0; t < sched.size(); t++)
         exp_deq_q.push_back({16'(le + 1 + t), sched[t]});
      exp_done_q.push_back(16'(le + 1 + sched.size()));
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [7:0] n);
      @(negedge clk);
      start    = 1'b1;
      num_rows = n;
      if (n == 0 || n > DEPTH) exp_err_q.push_back(16'(cyc + 1));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Streams nbeats weights; pattern bits pick wt_valid when rnd is 0.
   task automatic feed(input int rows, input int nbeats, input bit rnd, input logic [31:0] pat,
                       input logic [15:0] base, input int restart_at,
                       output logic [15:0] last_data);
      int            k = 0;
      int            i = 0;
      int unsigned   le = 0;
      logic          v;
      logic [15:0]   d;
      logic [NC-1:0] col;
      last_data = '0;
      while (k < nbeats && i < 400) begin
         @(negedge clk);
         v = rnd ? ($urandom_range(0, 3) != 0) : ((i < 32) ? pat[i] : 1'b1);
         d = rnd ? 16'($urandom_range(0, 65535)) : (base + 16'(k));
         bus.wt_valid = v;
         bus.wt_data  = d;
         start        = (i == restart_at);
         num_rows     = (i == restart_at) ? 8'd3 : num_rows;
         if (v && bus.wt_ready) begin
            col      = '0;
            col[k / rows] = 1'b1;
            exp_enq_q.push_back({16'(cyc + 1), col, d});
            le        = cyc + 1;
            last_data = d;
            k++;
         end
         i++;
      end
      check("feed_beats", 64'(k), 64'(nbeats));
      if (nbeats == rows * NC) begin
         expect_drain(rows, le);
         @(negedge clk);
         start = 1'b0;
         check("ready_after_last_beat", 64'(bus.wt_ready), 64'(0));
         @(negedge clk);
         bus.wt_valid = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_enq_q.size() + exp_deq_q.size() + exp_done_q.size() + exp_err_q.size() > 0
              || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_within_budget", 64'(n < budget), 64'(1));
      check("busy_idle", 64'(busy), 64'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  64'(busy), 64'(0));
      check({tag, "_ready"}, 64'(bus.wt_ready), 64'(0));
      check({tag, "_enq"},   64'(bus.acc_valid_data_out), 64'(0));
      check({tag, "_deq"},   64'(bus.acc_valid_in_out), 64'(0));
      check({tag, "_done"},  64'(done), 64'(0));
      check({tag, "_err"},   64'(err), 64'(0));
      check({tag, "_data"},  64'(bus.acc_data_out), 64'(0));
      check({tag, "_state"}, 64'(state), 64'(0));
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] ld;
   int          rr;

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      num_rows     = '0;
      bus.wt_valid = 1'b0;
      bus.wt_data  = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // held-valid job, data 1..4
      do_start(8'd2);
      feed(2, 4, 1'b0, 32'hFFFF_FFFF, 16'd1, -1, ld);
      wait_idle(50);

      // gapped valid pattern 1,0,0,1,1,0,1
      do_start(8'd2);
      feed(2, 4, 1'b0, 32'b1011001, 16'd1, -1, ld);
      wait_idle(50);

      // illegal row counts
      do_start(8'd0);
      check("err0_busy", 64'(busy), 64'(0));
      check("err0_ready", 64'(bus.wt_ready), 64'(0));
      do_start(8'd5);
      check("err5_busy", 64'(busy), 64'(0));
      wait_idle(20);

      // start during LOAD is ignored
      do_start(8'd2);
      feed(2, 4, 1'b0, 32'hFFFF_FFFF, 16'h100, 1, ld);
      wait_idle(50);

      // abort after 3 beats, then a one-row job
      do_start(8'd2);
      feed(2, 3, 1'b0, 32'hFFFF_FFFF, 16'h20, -1, ld);
      @(negedge clk);
      bus.wt_valid = 1'b0;
      abort        = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_ready", 64'(bus.wt_ready), 64'(0));
      check("abort_data_held", 64'(bus.acc_data_out), 64'(ld));
      do_start(8'd1);
      feed(1, 2, 1'b0, 32'hFFFF_FFFF, 16'd7, -1, ld);
      wait_idle(50);

      // asynchronous reset mid-drain
      do_start(8'd2);
      feed(2, 4, 1'b0, 32'hFFFF_FFFF, 16'h55, -1, ld);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_all_zero("async_rst");
      exp_enq_q.delete();
      exp_deq_q.delete();
      exp_done_q.delete();
      exp_err_q.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      do_start(8'd4);
      feed(4, 8, 1'b0, 32'hFFFF_FFFF, 16'h200, -1, ld);
      wait_idle(60);

      // randomized jobs, including illegal row counts
      for (int j = 0; j < 14; j++) begin
         rr = $urandom_range(0, DEPTH + 1);
         do_start(8'(rr));
         if (rr >= 1 && rr <= DEPTH) feed(rr, rr * NC, 1'b1, '0, '0, -1, ld);
         wait_idle(100);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
